// File: rtl/toggle_activity_monitor.sv
// Counts transitions and 1-samples of one observed bit over a programmable
// window of accepted samples, then holds the totals until the consumer takes them.
module toggle_activity_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_toggles,
    output logic [CNT_W-1:0] res_ones,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_win_len;
    logic [CNT_W-1:0] r_samples;
    logic [CNT_W-1:0] r_toggles;
    logic [CNT_W-1:0] r_ones;
    logic             r_prev;
    logic             r_prev_valid;
    logic [CNT_W-1:0] r_res_toggles;
    logic [CNT_W-1:0] r_res_ones;

    logic             w_accept;
    logic             w_toggle;
    logic             w_last;
    logic [CNT_W-1:0] w_samples_next;
    logic [CNT_W-1:0] w_toggles_next;
    logic [CNT_W-1:0] w_ones_next;

    // Samples never exceed win_len, so none of these sums can wrap.
    assign w_accept       = in_valid && (r_state == ST_COUNT);
    assign w_toggle       = r_prev_valid && (in_bit != r_prev);
    assign w_samples_next = r_samples + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_toggles_next = r_toggles + {{(CNT_W-1){1'b0}}, w_toggle};
    assign w_ones_next    = r_ones + {{(CNT_W-1){1'b0}}, in_bit};
    assign w_last         = (w_samples_next == r_win_len);

    // NOTE: every state register uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_win_len     <= '0;
            r_samples     <= '0;
            r_toggles     <= '0;
            r_ones        <= '0;
            r_prev        <= 1'b0;
            r_prev_valid  <= 1'b0;
            r_res_toggles <= '0;
            r_res_ones    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (win_len != '0)) begin
                        r_win_len    <= win_len;
                        r_samples    <= '0;
                        r_toggles    <= '0;
                        r_ones       <= '0;
                        r_prev       <= 1'b0;
                        r_prev_valid <= 1'b0;
                        r_state      <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_accept) begin
                        r_samples    <= w_samples_next;
                        r_toggles    <= w_toggles_next;
                        r_ones       <= w_ones_next;
                        r_prev       <= in_bit;
                        r_prev_valid <= 1'b1;
                        if (w_last) begin
                            r_res_toggles <= w_toggles_next;
                            r_res_ones    <= w_ones_next;
                            r_state       <= ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_COUNT);
    assign res_valid   = (r_state == ST_REPORT);
    assign busy        = (r_state != ST_IDLE);
    assign res_toggles = r_res_toggles;
    assign res_ones    = r_res_ones;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench: stimulus pushes expected window results into a scoreboard,
// a negedge monitor pops and compares each time a new result is presented.
module tb_toggle_activity_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_toggles;
    logic [CNT_W-1:0] res_ones;
    logic             busy;

    typedef struct {
        logic [CNT_W-1:0] tog;
        logic [CNT_W-1:0] ones;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic prev_rv = 1'b0;

    toggle_activity_monitor #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .win_len    (win_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_toggles(res_toggles),
        .res_ones   (res_ones),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare each freshly presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && prev_rv !== 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: result tog=%0d ones=%0d with empty scoreboard",
                         res_toggles, res_ones);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_toggles", 32'(res_toggles), 32'(e.tog));
                check("sb_ones", 32'(res_ones), 32'(e.ones));
            end
        end
        prev_rv = res_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input logic [CNT_W-1:0] len);
        start   = 1'b1;
        win_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic sample(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, "_rv_after_hs"}, 32'(res_valid), 0);
        check({name, "_busy_after_hs"}, 32'(busy), 0);
    endtask

    task automatic push_exp(input logic [CNT_W-1:0] t, input logic [CNT_W-1:0] o);
        exp_t e;
        e.tog  = t;
        e.ones = o;
        sb_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] alt;
        rst_n     = 1'b0;
        start     = 1'b1;
        win_len   = 16'd5;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        res_ready = 1'b0;

        // Reset with start and in_valid asserted.
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res_toggles", 32'(res_toggles), 0);
        check("rst_res_ones", 32'(res_ones), 0);
        start    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Alternating 0,1,...: 7 toggles, 4 ones.
        push_exp(16'd7, 16'd4);
        start_win(16'd8);
        check("alt_in_ready_start", 32'(in_ready), 1);
        check("alt_busy_start", 32'(busy), 1);
        alt = 16'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("alt_rv_before_last", 32'(res_valid), 0);
            sample(alt[i]);
        end
        check("alt_rv_after_last", 32'(res_valid), 1);
        check("alt_in_ready_after_last", 32'(in_ready), 0);
        check("alt_res_toggles", 32'(res_toggles), 7);
        handshake("alt");
        check("alt_res_kept", 32'(res_toggles), 7);

        // Gapped input: constant 1 with idle cycles offering in_bit=0.
        push_exp(16'd0, 16'd4);
        start_win(16'd4);
        for (int i = 0; i < 4; i++) begin
            sample(1'b1);
            if (i < 3) begin
                in_bit = 1'b0;
                tick();
                tick();
                check("gap_in_ready_idle", 32'(in_ready), 1);
            end
        end
        check("gap_rv", 32'(res_valid), 1);
        handshake("gap");

        // Backpressure: result held while start and in_valid pulse.
        push_exp(16'd1, 16'd1);
        start_win(16'd3);
        sample(1'b1);
        sample(1'b0);
        sample(1'b0);
        win_len = 16'd5;
        in_bit  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start    = i[0];
            in_valid = ~i[0];
            tick();
            check("bp_rv", 32'(res_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_toggles", 32'(res_toggles), 1);
            check("bp_ones", 32'(res_ones), 1);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        handshake("bp");

        // win_len = 0 is ignored.
        start_win(16'd0);
        check("zero_busy", 32'(busy), 0);
        tick();
        check("zero_busy_later", 32'(busy), 0);
        check("zero_in_ready", 32'(in_ready), 0);

        // Single-sample window.
        push_exp(16'd0, 16'd1);
        start_win(16'd1);
        sample(1'b1);
        check("one_rv", 32'(res_valid), 1);
        handshake("one");

        // Maximum window, constant 1: no wrap.
        push_exp(16'd0, 16'hFFFF);
        start_win(16'hFFFF);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        in_valid = 1'b0;
        check("max_rv", 32'(res_valid), 1);
        check("max_ones", 32'(res_ones), 32'hFFFF);
        handshake("max");

        // Mid-window reset discards the partial window and prev state.
        start_win(16'd6);
        sample(1'b0);
        sample(1'b1);
        sample(1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_in_ready", 32'(in_ready), 0);
        check("mrst_res_ones", 32'(res_ones), 0);
        push_exp(16'd0, 16'd2);
        start_win(16'd2);
        sample(1'b1);
        sample(1'b1);
        check("mrst_rv", 32'(res_valid), 1);
        handshake("mrst");

        tick();
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/toggle_activity_monitor.md
# toggle_activity_monitor

Sequential stage that sits directly downstream of the combinational power-experiment sub-circuits. It consumes one sub-circuit output bit per accepted sample and counts signal activity over a programmable window of samples. For each window it reports the number of output transitions and the number of 1-samples. The power flow uses these as switching-activity estimates when it compares rewritten and original circuits.

## Interface

Parameters:
- CNT_W, 16, width of the window length and of every counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  one-cycle request to open a window; honoured only in IDLE.
- win_len  input  CNT_W  number of samples in the window; sampled when start is honoured.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  monitor accepts a sample this cycle.
- in_bit  input  1  sub-circuit output bit under observation.
- res_valid  output  1  result registers hold a completed window.
- res_ready  input  1  consumer accepts the result.
- res_toggles  output  CNT_W  transitions between consecutive accepted samples.
- res_ones  output  CNT_W  accepted samples equal to 1.
- busy  output  1  high in COUNT or REPORT.

## Operation

- States are IDLE, COUNT and REPORT; encoding is free.
- IDLE:
  - in_ready=0, res_valid=0.
  - start=1 with win_len≠0: latch win_len, clear sample/toggle/ones counters, clear prev_valid, go to COUNT.
  - start=1 with win_len=0: ignored; stay in IDLE.
- COUNT:
  - in_ready=1.
  - A sample is accepted when in_valid and in_ready are both high.
  - Per accepted sample:
    - samples+1;
    - ones+in_bit;
    - toggles+1 if prev_valid and in_bit≠prev;
    - prev←in_bit, prev_valid←1.
  - The first sample of a window never counts as a toggle.
  - When the accepted sample is the win_len-th, copy the final counts into res_toggles/res_ones and go to REPORT.
- REPORT:
  - res_valid=1, in_ready=0.
  - res_* stay stable until the handshake.
  - res_valid and res_ready both high: go to IDLE.
- start is ignored in COUNT and REPORT.
- win_len changes after latching have no effect.
- Width rules:
  - toggles ≤ win_len−1 and ones ≤ win_len, so no counter overflows; no saturation logic is needed.
  - The maximum window is 2^CNT_W−1.
- in_bit is ignored whenever in_ready=0, including in_valid pulses while in IDLE or REPORT.
- Reset (rst_n=0 at any edge, including mid-window or mid-REPORT):
  - next state IDLE;
  - all counters, prev_valid and result registers cleared;
  - any partial window is discarded.

## Timing

- Reset values: in_ready=0, res_valid=0, res_toggles=0, res_ones=0, busy=0.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Window start:
  - start honoured at edge t.
  - in_ready=1 and busy=1 from cycle t+1.
- Result latency:
  - Final sample accepted at edge t.
  - res_valid=1 and in_ready=0 from cycle t+1.
  - res_* are valid in that same cycle.
- Result handshake:
  - Handshake at edge t.
  - res_valid=0 and busy=0 from t+1.
  - The earliest honoured start is at edge t+1, giving COUNT from t+2.
- res_* keep their last values after the handshake until the next window completes or reset.
- Throughput in COUNT is one sample per cycle; gaps in in_valid only stretch the window.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with start=1 and in_valid=1 → in_ready=0, res_valid=0, busy=0, res_toggles=0, res_ones=0.
- Alternating pattern:
  - win_len=8, in_bit 0,1,0,1,0,1,0,1 on consecutive cycles.
  - Expect res_toggles=7, res_ones=4.
  - res_valid rises exactly one cycle after the 8th sample; in_ready drops in the same cycle.
- Gapped input:
  - win_len=4, in_bit=1 ×4 with in_valid low for 2 cycles between samples.
  - Expect res_toggles=0, res_ones=4.
  - Samples offered while in_valid=0 with in_bit=0 do not count.
- Backpressure:
  - After a win_len=3 window (1,0,0), hold res_ready=0 for 10 cycles while pulsing start and in_valid.
  - Expect res_toggles=1, res_ones=1, both stable; in_ready=0; state unchanged.
  - Then raise res_ready → res_valid=0 the next cycle.
- Boundaries:
  - start with win_len=0 → stays IDLE, busy=0.
  - win_len=1 with in_bit=1 → res_toggles=0, res_ones=1.
  - win_len=2^CNT_W−1 with constant 1 → res_ones=2^CNT_W−1, res_toggles=0, no wrap.
- Mid-window reset:
  - win_len=6, accept 3 samples (0,1,0), then rst_n=0 for 1 cycle.
  - Expect IDLE, busy=0.
  - A new win_len=2 window with 1,1 reports res_toggles=0, res_ones=2, with no carry-over of prev or counts.
